// File: rtl/vu_pkg.sv
// Shared definitions for the VU level meter: magnitude width, peak FSM encoding
// and the saturating arithmetic helpers used by the level and peak paths.
package vu_pkg;

  localparam int              MAG_W   = 7;
  localparam logic [MAG_W-1:0] MAG_MAX = 7'd127;

  typedef logic [1:0] peak_state_t;
  localparam peak_state_t ST_IDLE = 2'd0;
  localparam peak_state_t ST_HOLD = 2'd1;
  localparam peak_state_t ST_FALL = 2'd2;

  // Offset-binary sample to magnitude; only 8'h00 (distance 128) saturates.
  function automatic logic [MAG_W-1:0] sample_mag(input logic [7:0] s);
    logic [7:0] m;
    m = s[7] ? (s - 8'h80) : (8'h80 - s);
    return (m > {1'b0, MAG_MAX}) ? MAG_MAX : m[MAG_W-1:0];
  endfunction

  function automatic logic [MAG_W-1:0] sub_floor(input logic [MAG_W-1:0] a,
                                                 input logic [7:0]       b);
    return ({1'b0, a} < b) ? '0 : (a - b[MAG_W-1:0]);
  endfunction

endpackage

// File: rtl/vu_tick_gen.sv
// Free-running divider: tick_o is high for the single cycle in which the
// counter sits at DIV-1, after which it wraps to zero.
module vu_tick_gen #(
  parameter int DIV = 1000000
) (
  input  logic clk,
  input  logic rst,
  output logic tick_o
);

  localparam int CW = $clog2(DIV);

  logic [CW-1:0] cnt_q;

  assign tick_o = (cnt_q == CW'(DIV - 1));

  // NOTE: sequential state is assigned with <= so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         cnt_q <= '0;
    else if (tick_o) cnt_q <= '0;
    else             cnt_q <= cnt_q + 1'b1;
  end

endmodule

// File: rtl/vu_level_meter.sv
// VU meter: fast-attack/slow-decay level, peak-hold marker and LED bar driven
// from the 1-cycle sample strobe of the UART receiver.
module vu_level_meter
  import vu_pkg::*;
#(
  parameter int LEDS       = 8,
  parameter int DECAY_DIV  = 1000000,
  parameter int DECAY_STEP = 1,
  parameter int HOLD_TICKS = 50,
  parameter int PEAK_STEP  = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       data,
  input  logic             data_valid,
  output logic [LEDS-1:0]  leds,
  output logic [MAG_W-1:0] level,
  output logic [MAG_W-1:0] peak,
  output logic             clip
);

  localparam int STEP = 128 / LEDS;
  localparam int HW   = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;

  logic             tick;
  logic [MAG_W-1:0] mag;
  logic [MAG_W-1:0] level_q, level_d;
  logic [MAG_W-1:0] peak_q, peak_d, peak_raw, fall_val;
  logic [HW-1:0]    hold_q, hold_d;
  peak_state_t      state_q, state_d;
  logic             clip_q, clip_d;
  logic [LEDS-1:0]  bar, dot;

  vu_tick_gen #(.DIV(DECAY_DIV)) u_tick (
    .clk    (clk),
    .rst    (rst),
    .tick_o (tick)
  );

  assign mag    = sample_mag(data);
  assign clip_d = data_valid && (mag == MAG_MAX);

  // NOTE: every always_comb output gets a default first, so no path leaves a
  // signal unassigned and no latch is inferred.
  always_comb begin
    level_d = level_q;
    if (data_valid && (mag > level_q)) level_d = mag;
    else if (tick)                     level_d = sub_floor(level_q, 8'(DECAY_STEP));
  end

  always_comb begin
    state_d  = state_q;
    hold_d   = hold_q;
    peak_raw = peak_q;
    fall_val = sub_floor(peak_q, 8'(PEAK_STEP));
    if (data_valid && (mag >= peak_q) && (mag != '0)) begin
      peak_raw = mag;
      hold_d   = '0;
      state_d  = ST_HOLD;
    end else begin
      case (state_q)
        ST_HOLD: begin
          if (tick) begin
            if (hold_q == HW'(HOLD_TICKS - 1)) state_d = ST_FALL;
            else                               hold_d  = hold_q + 1'b1;
          end
        end
        ST_FALL: begin
          if (tick) begin
            peak_raw = fall_val;
            if (fall_val == '0) state_d = ST_IDLE;
          end
        end
        default: begin
          peak_raw = '0;
          state_d  = ST_IDLE;
        end
      endcase
    end
    // The marker may never sit below the bar; raising it here leaves the state alone.
    peak_d = (peak_raw < level_d) ? level_d : peak_raw;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level_q <= '0;
      peak_q  <= '0;
      hold_q  <= '0;
      state_q <= ST_IDLE;
      clip_q  <= 1'b0;
    end else begin
      level_q <= level_d;
      peak_q  <= peak_d;
      hold_q  <= hold_d;
      state_q <= state_d;
      clip_q  <= clip_d;
    end
  end

  always_comb begin
    bar = '0;
    dot = '0;
    for (int i = 0; i < LEDS; i++) begin
      bar[i] = (level_q > MAG_W'(i * STEP));
      if (peak_q > MAG_W'(i * STEP)) begin
        dot    = '0;
        dot[i] = 1'b1;
      end
    end
  end

  assign leds  = bar | dot;
  assign level = level_q;
  assign peak  = peak_q;
  assign clip  = clip_q;

endmodule

// File: tb/tb_vu_level_meter.sv
// Self-checking bench for vu_level_meter: cycle model feeding a scoreboard plus
// directed checks of the attack, decay, clip, tick-collision and peak-dot cases.
module tb_vu_level_meter;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] data, h_data;
  logic       data_valid, h_valid;
  logic [7:0] leds, h_leds;
  logic [6:0] level, peak, h_level, h_peak;
  logic       clip, h_clip;

  always #5 clk = ~clk;

  vu_level_meter #(
    .LEDS(8), .DECAY_DIV(4), .DECAY_STEP(1), .HOLD_TICKS(3), .PEAK_STEP(2)
  ) u_dut (
    .clk(clk), .rst(rst), .data(data), .data_valid(data_valid),
    .leds(leds), .level(level), .peak(peak), .clip(clip)
  );

  // Long hold so a large peak/level gap is reachable for the dot encoding.
  vu_level_meter #(
    .LEDS(8), .DECAY_DIV(2), .DECAY_STEP(1), .HOLD_TICKS(60), .PEAK_STEP(2)
  ) u_hold (
    .clk(clk), .rst(rst), .data(h_data), .data_valid(h_valid),
    .leds(h_leds), .level(h_level), .peak(h_peak), .clip(h_clip)
  );

  typedef struct packed {
    logic [6:0] level;
    logic [6:0] peak;
    logic       clip;
    logic [7:0] leds;
  } exp_t;

  exp_t sb[$];
  exp_t sb_e;
  int   pass_cnt  = 0;
  int   total_cnt = 0;

  int m_level, m_peak, m_state, m_hold, m_cnt;

  function automatic int mag_of(input logic [7:0] d);
    int m;
    m = (d >= 8'd128) ? int'(d) - 128 : 128 - int'(d);
    return (m > 127) ? 127 : m;
  endfunction

  function automatic logic [7:0] leds_of(input int lv, input int pk);
    logic [7:0] r;
    int top;
    r   = '0;
    top = -1;
    for (int i = 0; i < 8; i++) begin
      if (lv > i * 16) r[i] = 1'b1;
      if (pk > i * 16) top = i;
    end
    if (top >= 0) r[top] = 1'b1;
    return r;
  endfunction

  task automatic model_reset();
    m_level = 0; m_peak = 0; m_state = 0; m_hold = 0; m_cnt = 0;
  endtask

  // One clock of the main DUT's behaviour; the expectation is queued for the checker.
  task automatic model_step(input logic v, input logic [7:0] d);
    int mag, nl, np;
    bit tk;
    mag   = mag_of(d);
    tk    = (m_cnt == 3);
    m_cnt = (m_cnt + 1) % 4;
    nl = m_level;
    if (v && mag > m_level) nl = mag;
    else if (tk)            nl = (m_level > 1) ? m_level - 1 : 0;
    np = m_peak;
    if (v && mag >= m_peak && mag != 0) begin
      np = mag; m_hold = 0; m_state = 1;
    end else if (m_state == 1) begin
      if (tk) begin
        if (m_hold == 2) m_state = 2;
        else             m_hold++;
      end
    end else if (m_state == 2) begin
      if (tk) begin
        np = (m_peak > 2) ? m_peak - 2 : 0;
        if (np == 0) m_state = 0;
      end
    end else begin
      np = 0;
    end
    if (np < nl) np = nl;
    m_level = nl;
    m_peak  = np;
    sb.push_back('{level: 7'(nl), peak: 7'(np), clip: (v && mag == 127), leds: leds_of(nl, np)});
  endtask

  task automatic drive(input logic v, input logic [7:0] d);
    data_valid = v;
    data       = d;
    model_step(v, d);
    @(posedge clk);
    @(negedge clk);
    data_valid = 1'b0;
  endtask

  // Called at a negedge; leaves reset released at the following negedge.
  task automatic pulse_reset();
    #2 rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    sb.delete();
  endtask

  always @(posedge clk) begin
    #1;
    if (sb.size() != 0) begin
      sb_e = sb.pop_front();
      total_cnt++;
      if ({level, peak, clip, leds} !== sb_e) begin
        $display("FAIL scoreboard t=%0t got level=%0d peak=%0d clip=%0b leds=%b, exp level=%0d peak=%0d clip=%0b leds=%b",
                 $time, level, peak, clip, leds, sb_e.level, sb_e.peak, sb_e.clip, sb_e.leds);
      end else pass_cnt++;
    end
  end

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    total_cnt++;
    if ({level, peak, clip, leds} !== 23'd0)
      $display("FAIL por_reset got level=%0d peak=%0d clip=%0b leds=%b, exp all zero", level, peak, clip, leds);
    else pass_cnt++;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_attack();
    drive(1'b1, 8'hC0);
    total_cnt++;
    if (level !== 7'd64) $display("FAIL attack_level got %0d exp 64", level); else pass_cnt++;
    total_cnt++;
    if (peak !== 7'd64) $display("FAIL attack_peak got %0d exp 64", peak); else pass_cnt++;
    total_cnt++;
    if (leds !== 8'b0000_1111) $display("FAIL attack_leds got %b exp 00001111", leds); else pass_cnt++;
    total_cnt++;
    if (clip !== 1'b0) $display("FAIL attack_clip got %0b exp 0", clip); else pass_cnt++;
  endtask

  task automatic test_decay();
    int n;
    n = 0;
    while (level !== 7'd63 && n < 8) begin drive(1'b0, 8'h80); n++; end
    total_cnt++;
    if (level !== 7'd63) $display("FAIL decay_first_step got %0d exp 63", level); else pass_cnt++;
    n = 0;
    while (level !== 7'd62 && n < 8) begin drive(1'b0, 8'h80); n++; end
    total_cnt++;
    if (n !== 4) $display("FAIL decay_period got %0d cycles exp 4", n); else pass_cnt++;
    n = 0;
    while (peak === 7'd64 && n < 40) begin drive(1'b0, 8'h80); n++; end
    total_cnt++;
    if (peak !== 7'd62 || level !== 7'd60)
      $display("FAIL peak_fall_start got peak=%0d level=%0d exp peak=62 level=60", peak, level);
    else pass_cnt++;
    n = 0;
    while (peak !== 7'd0 && n < 400) begin drive(1'b0, 8'h80); n++; end
    total_cnt++;
    if (peak !== 7'd0 || level !== 7'd0 || leds !== 8'h00)
      $display("FAIL decay_to_idle got peak=%0d level=%0d leds=%b exp 0/0/0", peak, level, leds);
    else pass_cnt++;
    repeat (6) drive(1'b0, 8'h80);
  endtask

  task automatic test_reset_mid_fall();
    drive(1'b1, 8'hC0);
    repeat (16) drive(1'b0, 8'h80);
    total_cnt++;
    if (peak !== 7'd62 || level !== 7'd60)
      $display("FAIL prefall_state got peak=%0d level=%0d exp peak=62 level=60", peak, level);
    else pass_cnt++;
    #2 rst = 1'b1;
    #1;
    total_cnt++;
    if ({level, peak, clip, leds} !== 23'd0)
      $display("FAIL async_reset got level=%0d peak=%0d clip=%0b leds=%b, exp all zero", level, peak, clip, leds);
    else pass_cnt++;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    sb.delete();
    repeat (2) drive(1'b0, 8'h80);
  endtask

  task automatic test_clip();
    pulse_reset();
    drive(1'b1, 8'h00);
    total_cnt++;
    if ({level, peak, clip, leds} !== {7'd127, 7'd127, 1'b1, 8'hFF})
      $display("FAIL clip_sample got level=%0d peak=%0d clip=%0b leds=%b exp 127/127/1/ff", level, peak, clip, leds);
    else pass_cnt++;
    drive(1'b0, 8'h80);
    total_cnt++;
    if (clip !== 1'b0 || level !== 7'd127)
      $display("FAIL clip_one_cycle got clip=%0b level=%0d exp 0/127", clip, level);
    else pass_cnt++;
    pulse_reset();
    drive(1'b1, 8'h7F);
    total_cnt++;
    if ({level, peak, leds} !== {7'd1, 7'd1, 8'h01})
      $display("FAIL mag_one got level=%0d peak=%0d leds=%b exp 1/1/00000001", level, peak, leds);
    else pass_cnt++;
    drive(1'b1, 8'h80);
    total_cnt++;
    if ({level, peak, clip} !== {7'd1, 7'd1, 1'b0})
      $display("FAIL mag_zero got level=%0d peak=%0d clip=%0b exp 1/1/0", level, peak, clip);
    else pass_cnt++;
  endtask

  task automatic test_tick_coincide();
    pulse_reset();
    drive(1'b1, 8'hB2);
    while (m_cnt != 3) drive(1'b0, 8'h80);
    total_cnt++;
    if (level !== 7'd50) $display("FAIL pre_tick_level got %0d exp 50", level); else pass_cnt++;
    drive(1'b1, 8'hE4);
    total_cnt++;
    if (level !== 7'd100) $display("FAIL attack_on_tick got %0d exp 100", level); else pass_cnt++;
    pulse_reset();
    drive(1'b1, 8'hB2);
    while (m_cnt != 3) drive(1'b0, 8'h80);
    drive(1'b1, 8'h8A);
    total_cnt++;
    if (level !== 7'd49 || peak !== 7'd50)
      $display("FAIL small_on_tick got level=%0d peak=%0d exp 49/50", level, peak);
    else pass_cnt++;
  endtask

  task automatic test_dot_hold();
    pulse_reset();
    h_data  = 8'hDA;
    h_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    h_valid = 1'b0;
    total_cnt++;
    if (h_level !== 7'd90 || h_peak !== 7'd90)
      $display("FAIL hold_attack got level=%0d peak=%0d exp 90/90", h_level, h_peak);
    else pass_cnt++;
    repeat (100) @(posedge clk);
    @(negedge clk);
    total_cnt++;
    if ({h_level, h_peak, h_leds} !== {7'd40, 7'd90, 8'b0010_0111})
      $display("FAIL dot_encode got level=%0d peak=%0d leds=%b exp 40/90/00100111", h_level, h_peak, h_leds);
    else pass_cnt++;
    h_data  = 8'hDF;
    h_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    h_valid = 1'b0;
    total_cnt++;
    if (h_level !== 7'd95 || h_peak !== 7'd95)
      $display("FAIL hold_restart got level=%0d peak=%0d exp 95/95", h_level, h_peak);
    else pass_cnt++;
    repeat (60) @(posedge clk);
    @(negedge clk);
    total_cnt++;
    if ({h_level, h_peak, h_clip, h_leds} !== {7'd65, 7'd95, 1'b0, 8'h3F})
      $display("FAIL hold_after_restart got level=%0d peak=%0d clip=%0b leds=%b exp 65/95/0/00111111",
               h_level, h_peak, h_clip, h_leds);
    else pass_cnt++;
  endtask

  initial begin
    rst        = 1'b1;
    data_valid = 1'b0;
    data       = 8'h80;
    h_valid    = 1'b0;
    h_data     = 8'h80;
    model_reset();
    test_reset();
    test_attack();
    test_decay();
    test_reset_mid_fall();
    test_clip();
    test_tick_coincide();
    test_dot_hold();
    @(negedge clk);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "timeout");
  end

endmodule
